mrnaiso_sequencer: RTL and testbench

MRNAISO_SEQUENCER -- requirements
Module: mrnaiso_sequencer

---
 rtl/mrnaiso_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_mrnaiso_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrnaiso_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mrnaiso_sequencer
// Purpose  : Multi-lane mRNA isolation valve/pump sequencer with timed phases.
// Revision : 1.0
// ============================================================================
module mrnaiso_sequencer #(
    parameter int CHANNELS = 5,
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CHANNELS-1:0] chan_en,
    input  logic [CNT_W-1:0]    t_fill,
    input  logic [CNT_W-1:0]    t_mix,
    input  logic [CNT_W-1:0]    t_sep,
    output logic [CHANNELS-1:0] chan_sel,
    output logic [12:0]         valves,
    output logic [3:0]          state,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int LANE_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIV_W  = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

    localparam logic [12:0] V_FILL    = 13'h0003;
    localparam logic [12:0] V_BEADS   = 13'h0006;
    localparam logic [12:0] V_LYSIS   = 13'h0018;
    localparam logic [12:0] V_SEP     = 13'h1300;
    localparam logic [12:0] V_COLLECT = 13'h0C00;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILL    = 4'd1,
        S_BEADS   = 4'd2,
        S_LYSIS   = 4'd3,
        S_MIX     = 4'd4,
        S_SEP     = 4'd5,
        S_COLLECT = 4'd6,
        S_NEXT    = 4'd7,
        S_FIN     = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    tfill_q, tfill_d;
    logic [CNT_W-1:0]    tmix_q, tmix_d;
    logic [CNT_W-1:0]    tsep_q, tsep_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          phase_q, phase_d;
    logic [12:0]         valves_q, valves_d;
    logic [CHANNELS-1:0] chan_sel_q, chan_sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic [LANE_W-1:0]   first_lane;
    logic [LANE_W-1:0]   next_lane;
    logic                has_next;
    logic                dwell_done;
    logic [CNT_W-1:0]    dwell_dec;

    // A zero duration still costs one clock, so the counter is loaded with D-1.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign dwell_done = (dwell_q == '0);
    assign dwell_dec  = dwell_q - CNT_W'(1);

    // Descending scan so the last hit is the lowest qualifying lane.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        has_next   = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (chan_en[i]) begin
                first_lane = LANE_W'(i);
            end
            if (mask_q[i] && (i > int'(lane_q))) begin
                next_lane = LANE_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        mask_d    = mask_q;
        tfill_d   = tfill_q;
        tmix_d    = tmix_q;
        tsep_d    = tsep_q;
        dwell_d   = dwell_q;
        div_d     = div_q;
        phase_d   = phase_q;
        aborted_d = 1'b0;

        if (state_q == S_IDLE) begin
            if (start && !abort) begin
                mask_d  = chan_en;
                tfill_d = t_fill;
                tmix_d  = t_mix;
                tsep_d  = t_sep;
                if (chan_en == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_FILL;
                    lane_d  = first_lane;
                    dwell_d = dwell_load(t_fill);
                end
            end
        end else if (abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (dwell_done) begin
                        state_d = S_BEADS;
                        dwell_d = dwell_load(tfill_q);
                    end else dwell_d = dwell_dec;
                end
                S_BEADS: begin
                    if (dwell_done) begin
                        state_d = S_LYSIS;
                        dwell_d = dwell_load(tfill_q);
                    end else dwell_d = dwell_dec;
                end
                S_LYSIS: begin
                    if (dwell_done) begin
                        state_d = S_MIX;
                        dwell_d = dwell_load(tmix_q);
                    end else dwell_d = dwell_dec;
                end
                S_MIX: begin
                    if (dwell_done) begin
                        state_d = S_SEP;
                        dwell_d = dwell_load(tsep_q);
                    end else dwell_d = dwell_dec;
                end
                S_SEP: begin
                    if (dwell_done) begin
                        state_d = S_COLLECT;
                        dwell_d = dwell_load(tsep_q);
                    end else dwell_d = dwell_dec;
                end
                S_COLLECT: begin
                    if (dwell_done) state_d = S_NEXT;
                    else            dwell_d = dwell_dec;
                end
                S_NEXT: begin
                    if (has_next) begin
                        state_d = S_FILL;
                        lane_d  = next_lane;
                        dwell_d = dwell_load(tfill_q);
                    end else begin
                        state_d = S_FIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Pump rotation restarts at pump1 on every MIX entry.
        if (state_d == S_MIX) begin
            if (state_q != S_MIX) begin
                div_d   = '0;
                phase_d = 2'd0;
            end else if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        case (state_d)
            S_FILL:    valves_d = V_FILL;
            S_BEADS:   valves_d = V_BEADS;
            S_LYSIS:   valves_d = V_LYSIS;
            S_MIX: begin
                case (phase_d)
                    2'd0:    valves_d = 13'h0020;
                    2'd1:    valves_d = 13'h0040;
                    default: valves_d = 13'h0080;
                endcase
            end
            S_SEP:     valves_d = V_SEP;
            S_COLLECT: valves_d = V_COLLECT;
            default:   valves_d = '0;
        endcase

        if ((state_d >= S_FILL) && (state_d <= S_COLLECT)) begin
            chan_sel_d = CHANNELS'(1) << lane_d;
        end else begin
            chan_sel_d = '0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            mask_q     <= '0;
            tfill_q    <= '0;
            tmix_q     <= '0;
            tsep_q     <= '0;
            dwell_q    <= '0;
            div_q      <= '0;
            phase_q    <= '0;
            valves_q   <= '0;
            chan_sel_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            mask_q     <= mask_d;
            tfill_q    <= tfill_d;
            tmix_q     <= tmix_d;
            tsep_q     <= tsep_d;
            dwell_q    <= dwell_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            valves_q   <= valves_d;
            chan_sel_q <= chan_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign state    = state_q;
    assign valves   = valves_q;
    assign chan_sel = chan_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_mrnaiso_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mrnaiso_sequencer
// Purpose  : Trace-schedule reference model plus directed boundary scenarios.
// Revision : 1.0
// ============================================================================
module tb_mrnaiso_sequencer;

    localparam int CH = 5;
    localparam int CW = 16;
    localparam int PD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CH-1:0] chan_en = '0;
    logic [CW-1:0] t_fill = '0;
    logic [CW-1:0] t_mix = '0;
    logic [CW-1:0] t_sep = '0;
    logic [CH-1:0] chan_sel;
    logic [12:0]   valves;
    logic [3:0]    state;
    logic          busy;
    logic          done;
    logic          aborted;

    always #5 clk = ~clk;

    mrnaiso_sequencer #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .PUMP_DIV (PD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .chan_en  (chan_en),
        .t_fill   (t_fill),
        .t_mix    (t_mix),
        .t_sep    (t_sep),
        .chan_sel (chan_sel),
        .valves   (valves),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    typedef struct packed {
        logic [3:0]    st;
        logic [12:0]   v;
        logic [CH-1:0] cs;
        logic          dn;
    } exp_t;

    localparam exp_t IDLE_E = '{4'd0, 13'd0, {CH{1'b0}}, 1'b0};

    exp_t q[$];
    exp_t cur    = IDLE_E;
    logic exp_ab = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   done_at, done_cnt, mix_k, busy_cnt, vnz, mix_cnt, found;
    int   st_cnt [9];
    logic [2:0]    pumps [6];
    logic [CH-1:0] mix_cs [6];
    logic [2:0]    exp_p [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dur(input logic [CW-1:0] t);
        return (t == '0) ? 1 : int'(t);
    endfunction

    task automatic push_n(input int n, input logic [3:0] st, input logic [12:0] v,
                          input logic [CH-1:0] cs);
        for (int k = 0; k < n; k++) q.push_back('{st, v, cs, 1'b0});
    endtask

    // Expected per-cycle output trace of a whole run, lane by lane.
    task automatic build_run(input logic [CH-1:0] m, input logic [CW-1:0] tf,
                             input logic [CW-1:0] tm, input logic [CW-1:0] ts);
        logic [CH-1:0] cs;
        for (int l = 0; l < CH; l++) begin
            if (m[l]) begin
                cs    = '0;
                cs[l] = 1'b1;
                push_n(dur(tf), 4'd1, 13'h0003, cs);
                push_n(dur(tf), 4'd2, 13'h0006, cs);
                push_n(dur(tf), 4'd3, 13'h0018, cs);
                for (int k = 0; k < dur(tm); k++)
                    q.push_back('{4'd4, 13'h0020 << ((k / PD) % 3), cs, 1'b0});
                push_n(dur(ts), 4'd5, 13'h1300, cs);
                push_n(dur(ts), 4'd6, 13'h0C00, cs);
                push_n(1, 4'd7, 13'h0000, '0);
            end
        end
        q.push_back('{4'd8, 13'h0000, {CH{1'b0}}, 1'b1});
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            cur    = IDLE_E;
            exp_ab = 1'b0;
        end else begin
            exp_ab = 1'b0;
            if (abort && (cur.st != 4'd0)) begin
                q.delete();
                cur    = IDLE_E;
                exp_ab = 1'b1;
            end else begin
                if ((cur.st == 4'd0) && start && !abort)
                    build_run(chan_en, t_fill, t_mix, t_sep);
                cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("state",    32'(state),    32'(cur.st));
            check("valves",   32'(valves),   32'(cur.v));
            check("chan_sel", 32'(chan_sel), 32'(cur.cs));
            check("busy",     32'(busy),     32'(cur.st != 4'd0));
            check("done",     32'(done),     32'(cur.dn));
            check("aborted",  32'(aborted),  32'(exp_ab));
        end
    end

    task automatic pulse_start(input logic [CH-1:0] m, input logic [CW-1:0] tf,
                               input logic [CW-1:0] tm, input logic [CW-1:0] ts);
        @(posedge clk);
        #1;
        chan_en = m;
        t_fill  = tf;
        t_mix   = tm;
        t_sep   = ts;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   32'(state),    32'd0);
        check("rst_valves",  32'(valves),   32'd0);
        check("rst_chansel", 32'(chan_sel), 32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_done",    32'(done),     32'd0);
        check("rst_aborted", 32'(aborted),  32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Two-lane reference run: lanes 0 and 2.
        pulse_start(5'b00101, 16'd2, 16'd6, 16'd3);
        check("A_model_queue", 32'(q.size()), 32'd38);
        done_at = -1; done_cnt = 0; mix_k = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if ((state == 4'd4) && (mix_k < 6)) begin
                pumps[mix_k]  = {valves[5], valves[6], valves[7]};
                mix_cs[mix_k] = chan_sel;
                mix_k++;
            end
        end
        check("A_done_cycle", 32'(done_at),  32'd39);
        check("A_done_count", 32'(done_cnt), 32'd1);
        check("A_mix_cycles", 32'(mix_k),    32'd6);
        exp_p = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
        for (int k = 0; k < 6; k++) begin
            check("A_pump_seq",    32'(pumps[k]),  32'(exp_p[k]));
            check("A_mix_chansel", 32'(mix_cs[k]), 32'd1);
        end

        // Empty mask goes straight to FIN.
        pulse_start(5'b00000, 16'd4, 16'd4, 16'd4);
        busy_cnt = 0; done_at = -1; vnz = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && (done_at < 0)) done_at = n;
            if (valves != '0) vnz++;
            if (n == 1) check("B_state_fin", 32'(state), 32'd8);
        end
        check("B_busy_cycles", 32'(busy_cnt), 32'd1);
        check("B_done_cycle",  32'(done_at),  32'd1);
        check("B_valves_zero", 32'(vnz),      32'd0);

        // Abort during the third MIX cycle.
        pulse_start(5'b00001, 16'd1, 16'd6, 16'd1);
        mix_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (state == 4'd4) mix_cnt++;
            if (mix_cnt == 3) begin
                abort = 1'b1;
                break;
            end
        end
        check("C_reached_mix3", 32'(mix_cnt), 32'd3);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("C_state",    32'(state),    32'd0);
        check("C_valves",   32'(valves),   32'd0);
        check("C_chansel",  32'(chan_sel), 32'd0);
        check("C_aborted",  32'(aborted),  32'd1);
        done_cnt = 0;
        if (done) done_cnt++;
        @(negedge clk);
        check("C_aborted_pulse", 32'(aborted), 32'd0);
        for (int n = 0; n < 5; n++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("C_no_done", 32'(done_cnt), 32'd0);

        // Zero fill duration still spends one clock in each fill-timed state.
        pulse_start(5'b10000, 16'd0, 16'd2, 16'd1);
        for (int s = 0; s < 9; s++) st_cnt[s] = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            st_cnt[state]++;
        end
        check("D_fill_len",  32'(st_cnt[1]), 32'd1);
        check("D_beads_len", 32'(st_cnt[2]), 32'd1);
        check("D_lysis_len", 32'(st_cnt[3]), 32'd1);
        check("D_mix_len",   32'(st_cnt[4]), 32'd2);

        // A second start mid-run is ignored.
        pulse_start(5'b00011, 16'd1, 16'd2, 16'd1);
        done_at = -1; done_cnt = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 5) begin
                start   = 1'b1;
                chan_en = 5'b11111;
                t_fill  = 16'd7;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
        end
        check("E_done_cycle", 32'(done_at),  32'd17);
        check("E_done_count", 32'(done_cnt), 32'd1);

        // Reset dropped during SEP clears outputs before the next edge.
        pulse_start(5'b00100, 16'd1, 16'd1, 16'd3);
        found = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (state == 4'd5) begin
                found = 1;
                break;
            end
        end
        check("F_reached_sep", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("F_state",   32'(state),    32'd0);
        check("F_valves",  32'(valves),   32'd0);
        check("F_chansel", 32'(chan_sel), 32'd0);
        check("F_busy",    32'(busy),     32'd0);
        check("F_done",    32'(done),     32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Abort and start together in IDLE: abort wins.
        @(posedge clk);
        #1;
        chan_en = 5'b00001;
        start   = 1'b1;
        abort   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("G_state",   32'(state),   32'd0);
        check("G_aborted", 32'(aborted), 32'd0);

        // Randomised runs with stray starts and occasional aborts.
        for (int r = 0; r < 40; r++) begin
            pulse_start(5'($urandom_range(0, 31)), 16'($urandom_range(0, 3)),
                        16'($urandom_range(0, 7)), 16'($urandom_range(0, 3)));
            found = 0;
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                if (state == 4'd0) begin
                    found = 1;
                    break;
                end
                if ($urandom_range(0, 59) == 0) abort = 1'b1;
                if ($urandom_range(0, 14) == 0) begin
                    start   = 1'b1;
                    chan_en = 5'($urandom_range(0, 31));
                    t_fill  = 16'($urandom_range(0, 9));
                end
            end
            check("R_run_ends", 32'(found), 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
